// File: rtl/afifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port for N requesters; AFIFO_ARB_TAG_EN prepends the owner index to each word.
// Latency: fifo_wen/fifo_wdata are combinational from the owner's request; one idle cycle between grants.
// Backpressure: fifo_full stalls the owner (req_ready low, burst count held); other requesters wait their turn.
module afifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int BURST = 4,
  localparam int IDW  = $clog2(N),
`ifdef AFIFO_ARB_TAG_EN
  localparam int FW   = IDW + DW
`else
  localparam int FW   = DW
`endif
) (
  input  logic            wclk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_wen,
  output logic [FW-1:0]   fifo_wdata,
  output logic [IDW-1:0]  grant_id,
  output logic            busy
);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] winner, idx;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           owner_vld, beat;
  logic [DW-1:0]  owner_dat;

  assign owner_vld = req_valid[owner];
  assign owner_dat = req_data[owner*DW +: DW];

  // Scan downward so the requester closest to rr_ptr is the last to overwrite.
  always_comb begin
    winner = rr_ptr;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % N);
      if (req_valid[idx]) winner = idx;
    end
  end

  always_comb begin
    req_ready = '0;
    beat      = 1'b0;
    if (state == ST_BURST && !rst) begin
      req_ready[owner] = ~fifo_full;
      beat             = owner_vld & ~fifo_full;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt = ST_BURST;
          owner_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      ST_BURST: begin
        if (!owner_vld || (beat && cnt == CW'(BURST - 1))) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
          cnt_nxt    = '0;
        end else if (beat) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign fifo_wen = beat;
  assign busy     = (state == ST_BURST);
  assign grant_id = owner;

`ifdef AFIFO_ARB_TAG_EN
  assign fifo_wdata = {owner, owner_dat};
`else
  assign fifo_wdata = owner_dat;
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter (N=4, DW=8, BURST=4); inputs change on negedge, outputs sampled 1ns later.
module tb_afifo_wr_arbiter;
`ifdef AFIFO_ARB_TAG_EN
  localparam int FW_TB = 10;
`else
  localparam int FW_TB = 8;
`endif

  logic             wclk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [31:0]      req_data;
  logic [3:0]       req_ready;
  logic             fifo_full;
  logic             fifo_wen;
  logic [FW_TB-1:0] fifo_wdata;
  logic [1:0]       grant_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  afifo_wr_arbiter #(.N(4), .DW(8), .BURST(4)) dut (
    .wclk(wclk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

`ifdef AFIFO_ARB_TAG_EN
  function automatic logic [FW_TB-1:0] exp_word(input int g, input logic [7:0] d);
    return {2'(g), d};
  endfunction
`else
  function automatic logic [FW_TB-1:0] exp_word(input int g, input logic [7:0] d);
    return (g >= 0) ? d : d;
  endfunction
`endif

  task automatic do_reset();
    @(negedge wclk);
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; req_data = '0;
    @(negedge wclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; fifo_full = 1'b0; req_data = 32'h44332211;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1;
      checks++; if (fifo_wen !== 1'b0) begin errors++; $display("FAIL reset_wen c%0d got %b exp 0", c, fifo_wen); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready c%0d got %b exp 0000", c, req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c%0d got %b exp 0", c, busy); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant c%0d got %0d exp 0", c, grant_id); end
    end
  endtask

  // Lone requester 2 with 6 words: split into a 4-beat and a 2-beat grant.
  task automatic test_single();
    bit ew [10] = '{0,1,1,1,1,0,1,1,0,0};
    bit eb [10] = '{0,1,1,1,1,0,1,1,1,0};
    int w = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      req_valid = (w < 6) ? 4'b0100 : 4'b0000;
      req_data[16 +: 8] = 8'(8'h20 + w);
      #1;
      checks++; if (fifo_wen !== ew[c]) begin errors++; $display("FAIL single_wen c%0d got %b exp %b", c, fifo_wen, ew[c]); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL single_busy c%0d got %b exp %b", c, busy, eb[c]); end
      checks++; if (req_ready !== (eb[c] ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_ready c%0d got %b", c, req_ready); end
      if (eb[c]) begin
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant c%0d got %0d exp 2", c, grant_id); end
      end
      if (ew[c]) begin
        checks++; if (fifo_wdata !== exp_word(2, 8'(8'h20 + w))) begin errors++; $display("FAIL single_data c%0d got %h exp %h", c, fifo_wdata, exp_word(2, 8'(8'h20 + w))); end
        w++;
      end
    end
  endtask

  // All four requesting: grants rotate 0,1,2,3,0 with one idle cycle each.
  task automatic test_all_rr();
    int sent [4] = '{0,0,0,0};
    for (int c = 0; c < 25; c++) begin
      int g;
      bit eb;
      g = (c / 5) % 4;
      eb = (c % 5) != 0;
      @(negedge wclk);
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i * 16 + sent[i]);
      #1;
      checks++; if (busy !== eb) begin errors++; $display("FAIL rr_busy c%0d got %b exp %b", c, busy, eb); end
      checks++; if (fifo_wen !== eb) begin errors++; $display("FAIL rr_wen c%0d got %b exp %b", c, fifo_wen, eb); end
      checks++; if (req_ready !== (eb ? 4'(1 << g) : 4'b0)) begin errors++; $display("FAIL rr_ready c%0d got %b exp grant %0d", c, req_ready, g); end
      if (eb) begin
        checks++; if (grant_id !== 2'(g)) begin errors++; $display("FAIL rr_grant c%0d got %0d exp %0d", c, grant_id, g); end
        checks++; if (fifo_wdata !== exp_word(g, 8'(g * 16 + sent[g]))) begin errors++; $display("FAIL rr_data c%0d got %h exp %h", c, fifo_wdata, exp_word(g, 8'(g * 16 + sent[g]))); end
        sent[g]++;
      end
    end
  endtask

  // Requester 1 stalled by fifo_full for 3 cycles after beat 2.
  task automatic test_full_stall();
    bit ef [9] = '{0,0,0,1,1,1,0,0,0};
    bit ew [9] = '{0,1,1,0,0,0,1,1,0};
    bit eb [9] = '{0,1,1,1,1,1,1,1,0};
    int k = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge wclk);
      req_valid = (c < 8) ? 4'b0010 : 4'b0000;
      fifo_full = ef[c];
      req_data[8 +: 8] = 8'(8'h10 + k);
      #1;
      checks++; if (fifo_wen !== ew[c]) begin errors++; $display("FAIL full_wen c%0d got %b exp %b", c, fifo_wen, ew[c]); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL full_busy c%0d got %b exp %b", c, busy, eb[c]); end
      checks++; if (req_ready !== ((eb[c] && !ef[c]) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL full_ready c%0d got %b", c, req_ready); end
      if (ew[c]) begin
        checks++; if (fifo_wdata !== exp_word(1, 8'(8'h10 + k))) begin errors++; $display("FAIL full_data c%0d got %h exp %h", c, fifo_wdata, exp_word(1, 8'(8'h10 + k))); end
        k++;
      end
    end
    fifo_full = 1'b0;
  endtask

  // Requester 0 drops after one beat; rr_ptr moves to 1 so req 3 beats a re-raised req 0.
  task automatic test_drop();
    bit v0 [5] = '{1,1,0,1,1};
    bit ew [5] = '{0,1,0,0,1};
    bit eb [5] = '{0,1,1,0,1};
    int eg [5] = '{0,0,0,0,3};
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      req_valid = {1'b1, 2'b00, v0[c]};
      req_data = 32'h3C00_0050;
      #1;
      checks++; if (fifo_wen !== ew[c]) begin errors++; $display("FAIL drop_wen c%0d got %b exp %b", c, fifo_wen, ew[c]); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL drop_busy c%0d got %b exp %b", c, busy, eb[c]); end
      checks++; if (req_ready !== (eb[c] ? 4'(1 << eg[c]) : 4'b0)) begin errors++; $display("FAIL drop_ready c%0d got %b", c, req_ready); end
      if (eb[c]) begin
        checks++; if (grant_id !== 2'(eg[c])) begin errors++; $display("FAIL drop_grant c%0d got %0d exp %0d", c, grant_id, eg[c]); end
      end
      if (ew[c]) begin
        checks++; if (fifo_wdata !== exp_word(eg[c], (eg[c] == 3) ? 8'h3C : 8'h50)) begin errors++; $display("FAIL drop_data c%0d got %h", c, fifo_wdata); end
      end
    end
  endtask

  // Reset at beat 2 suppresses the write and abandons the burst; a fresh full burst follows.
  task automatic test_rst_mid();
    bit er [9] = '{0,0,1,0,0,0,0,0,0};
    bit ew [9] = '{0,1,0,0,1,1,1,1,0};
    bit eb [9] = '{0,1,1,0,1,1,1,1,0};
    for (int c = 0; c < 9; c++) begin
      @(negedge wclk);
      rst = er[c];
      req_valid = (c < 8) ? 4'b1000 : 4'b0000;
      req_data = 32'hA500_0000;
      #1;
      checks++; if (fifo_wen !== ew[c]) begin errors++; $display("FAIL rstmid_wen c%0d got %b exp %b", c, fifo_wen, ew[c]); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL rstmid_busy c%0d got %b exp %b", c, busy, eb[c]); end
      checks++; if (req_ready !== ((eb[c] && !er[c]) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL rstmid_ready c%0d got %b", c, req_ready); end
      if (c == 3) begin
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_grant c%0d got %0d exp 0", c, grant_id); end
      end
      if (ew[c]) begin
        checks++; if (fifo_wdata !== exp_word(3, 8'hA5)) begin errors++; $display("FAIL rstmid_data c%0d got %h exp %h", c, fifo_wdata, exp_word(3, 8'hA5)); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    test_reset();
    do_reset();
    test_single();
    do_reset();
    test_all_rr();
    do_reset();
    test_full_stall();
    do_reset();
    test_drop();
    do_reset();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
